k2_run_control: RTL and testbench

Run/load controller for the K2 processor core. Owns the 16×8 program memory that feeds the core's `instruction_data`. It loads programs through a valid/ready stream and holds the core in reset while doing so. It sequences execution by gating `PC_en` in free-run (rate-divided), single-step and halt modes, and detects the self-jump halt idiom.

---
 rtl/k2_ctrl_pkg.sv | 19 +
 rtl/k2_run_control_if.sv | 32 +++
 rtl/k2_rate_divider.sv | 35 +++
 rtl/k2_run_control.sv | 110 +++++++++++
 tb/tb_k2_run_control.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/k2_ctrl_pkg.sv
// Shared types and helpers for the K2 run/load controller.
package k2_ctrl_pkg;

   localparam int PROG_DEPTH = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      STEP = 3'd3,
      HALT = 3'd4
   } state_t;

   // A jump (10xx_x) whose low target bits equal the PC, only reachable in the lower half.
   function automatic logic is_self_jump(input logic [7:0] instr, input logic [3:0] pc);
      return ((instr & 8'hC7) == {5'b10000, pc[2:0]}) && !pc[3];
   endfunction

endpackage

// File: rtl/k2_run_control_if.sv
// Command, program-stream and core-facing signals of the K2 run controller.
interface k2_run_control_if #(
   parameter int DivWidth = 4,
   parameter int CntBits  = 8
);
   logic                load_req;
   logic                start;
   logic                step;
   logic                stop;
   logic [DivWidth-1:0] div;
   logic                prog_valid;
   logic [7:0]          prog_data;
   logic                prog_last;
   logic                prog_ready;
   logic [3:0]          ProgramAddress;
   logic [7:0]          instruction_data;
   logic                PC_en;
   logic                proc_rst_n;
   logic                halted;
   logic                busy;
   logic [CntBits-1:0]  instr_count;

   modport master (
      output load_req, start, step, stop, div, prog_valid, prog_data, prog_last, ProgramAddress,
      input  prog_ready, instruction_data, PC_en, proc_rst_n, halted, busy, instr_count
   );

   modport slave (
      input  load_req, start, step, stop, div, prog_valid, prog_data, prog_last, ProgramAddress,
      output prog_ready, instruction_data, PC_en, proc_rst_n, halted, busy, instr_count
   );
endinterface

// File: rtl/k2_rate_divider.sv
// Cycles-per-instruction divider: ticks when the count reaches div, then restarts at 0.
module k2_rate_divider #(
   parameter int DivWidth = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                clr_i,
   input  logic [DivWidth-1:0] div_i,
   output logic                tick_o
);

   logic [DivWidth-1:0] cnt_q, cnt_d;

   // >= lets a lowered div fire immediately instead of wrapping the counter.
   assign tick_o = en_i && (cnt_q >= div_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + DivWidth'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/k2_run_control.sv
// K2 run/load controller: owns the program memory and sequences PC_en and core reset.
module k2_run_control
   import k2_ctrl_pkg::*;
#(
   parameter int DivWidth = 4,
   parameter int CntBits  = 8
) (
   input logic             clk,
   input logic             rst_n,
   k2_run_control_if.slave ctrl
);

   state_t             state_q, state_d;
   logic [7:0]         mem_q [PROG_DEPTH];
   logic [3:0]         wptr_q, wptr_d;
   logic [CntBits-1:0] count_q, count_d;
   logic               proc_rst_n_q;
   logic [7:0]         instrWord;
   logic               inRun, runTick, handshake, wrEn, pcEn, selfJump;

   assign inRun     = (state_q == RUN);
   assign handshake = ctrl.prog_valid && (state_q == LOAD);
   assign instrWord = mem_q[ctrl.ProgramAddress];
   assign selfJump  = is_self_jump(instrWord, ctrl.ProgramAddress);
   assign pcEn      = (inRun && runTick && !ctrl.stop) || (state_q == STEP);

   k2_rate_divider #(.DivWidth(DivWidth)) u_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (inRun),
      .clr_i  (!inRun),
      .div_i  (ctrl.div),
      .tick_o (runTick)
   );

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      wrEn    = 1'b0;
      case (state_q)
         IDLE, HALT: begin
            if (ctrl.load_req)   state_d = LOAD;
            else if (ctrl.start) state_d = RUN;
            else if (ctrl.step)  state_d = STEP;
         end
         LOAD: begin
            // An abort drops a coincident word rather than writing it.
            if (ctrl.stop) begin
               state_d = IDLE;
               wptr_d  = '0;
            end else if (handshake) begin
               wrEn = 1'b1;
               if (ctrl.prog_last || wptr_q == 4'(PROG_DEPTH - 1)) begin
                  state_d = IDLE;
                  wptr_d  = '0;
               end else begin
                  wptr_d = wptr_q + 4'd1;
               end
            end
         end
         RUN: begin
            if (ctrl.stop || (runTick && selfJump)) state_d = HALT;
         end
         STEP:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (state_q == IDLE || state_q == LOAD) begin
         count_d = '0;
      end else if (pcEn && count_q != '1) begin
         count_d = count_q + CntBits'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         count_q      <= '0;
         proc_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         count_q      <= count_d;
         proc_rst_n_q <= (state_d inside {RUN, STEP, HALT});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PROG_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wrEn) begin
         mem_q[wptr_q] <= ctrl.prog_data;
      end
   end

   assign ctrl.instruction_data = instrWord;
   assign ctrl.prog_ready       = (state_q == LOAD);
   assign ctrl.PC_en            = pcEn;
   assign ctrl.proc_rst_n       = proc_rst_n_q;
   assign ctrl.halted           = (state_q == HALT);
   assign ctrl.busy             = (state_q inside {LOAD, RUN, STEP});
   assign ctrl.instr_count      = count_q;

endmodule

// File: tb/tb_k2_run_control.sv
// Randomized self-checking bench for k2_run_control; expectations come from
// strobe-schedule arithmetic and an array model of the program memory.
module tb_k2_run_control;

   localparam int DivW = 4;
   localparam int CntW = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #20 clk = ~clk;

   k2_run_control_if #(.DivWidth(DivW), .CntBits(CntW)) bus ();

   k2_run_control #(.DivWidth(DivW), .CntBits(CntW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus)
   );

   int         checkCount = 0;
   int         errorCount = 0;
   logic [7:0] modelMem  [16];
   logic [7:0] progWords [17];
   logic [3:0] corePc;
   logic       useOverride  = 1'b0;
   logic [3:0] overrideAddr = '0;

   // Stand-in core: walks sequentially and follows 10xx_xxxx jumps.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               corePc <= '0;
      else if (!bus.proc_rst_n) corePc <= '0;
      else if (bus.PC_en)
         corePc <= (bus.instruction_data[7:6] == 2'b10) ? bus.instruction_data[3:0] : corePc + 4'd1;
   end
   assign bus.ProgramAddress = useOverride ? overrideAddr : corePc;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic loadReq, input logic startCmd, input logic stepCmd, input logic stopCmd);
      bus.load_req = loadReq;
      bus.start    = startCmd;
      bus.step     = stepCmd;
      bus.stop     = stopCmd;
   endtask

   task automatic pulse(input logic loadReq, input logic startCmd, input logic stepCmd, input logic stopCmd);
      applyStimulus(loadReq, startCmd, stepCmd, stopCmd);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkMemory(input string tag);
      @(negedge clk);
      useOverride = 1'b1;
      for (int i = 0; i < 16; i++) begin
         overrideAddr = 4'(i);
         #1;
         checkOutput($sformatf("%s_mem%0d", tag, i), 32'(bus.instruction_data), 32'(modelMem[i]));
      end
      useOverride = 1'b0;
      nextCycle();
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_pc_en"},      32'(bus.PC_en),       32'd0);
      checkOutput({tag, "_prog_ready"}, 32'(bus.prog_ready),  32'd0);
      checkOutput({tag, "_proc_rst_n"}, 32'(bus.proc_rst_n),  32'd0);
      checkOutput({tag, "_halted"},     32'(bus.halted),      32'd0);
      checkOutput({tag, "_busy"},       32'(bus.busy),        32'd0);
      checkOutput({tag, "_count"},      32'(bus.instr_count), 32'd0);
   endtask

   // Offers progWords[0..nWords-1] with random gaps; the model accepts words until
   // the flagged last word or the 16th word, and drops anything offered afterwards.
   task automatic loadProgram(input int nWords, input bit flagLast, output int accepted);
      int   idx = 0;
      int   guard = 0;
      int   readyErr = 0;
      int   rstErr = 0;
      int   modelPtr = 0;
      bit   modelActive = 1'b1;
      logic offered, lastFlag;
      accepted = 0;
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      while (idx < nWords && guard < 400) begin
         offered        = ($urandom_range(3) != 0);
         lastFlag       = flagLast && (idx == nWords - 1);
         bus.prog_valid = offered;
         bus.prog_data  = progWords[idx];
         bus.prog_last  = lastFlag;
         @(negedge clk);
         if (bus.prog_ready !== modelActive) readyErr++;
         if (bus.proc_rst_n !== 1'b0)        rstErr++;
         if (offered && bus.prog_ready === 1'b1) accepted++;
         if (offered) begin
            if (modelActive) begin
               modelMem[modelPtr] = progWords[idx];
               modelPtr++;
               if (lastFlag || modelPtr == 16) begin
                  modelActive = 1'b0;
                  modelPtr    = 0;
               end
            end
            idx++;
         end
         guard++;
         nextCycle();
      end
      bus.prog_valid = 1'b0;
      bus.prog_last  = 1'b0;
      checkOutput("load_all_offered", 32'(idx), 32'(nWords));
      checkOutput("load_ready_trace", 32'(readyErr), 32'd0);
      checkOutput("load_core_in_reset", 32'(rstErr), 32'd0);
      @(negedge clk);
      checkOutput("load_done_busy", 32'(bus.busy), 32'd0);
      checkOutput("load_done_ready", 32'(bus.prog_ready), 32'd0);
      nextCycle();
   endtask

   // Program with a self-jump at word k: expect k+1 strobes spaced d+1 apart, then HALT.
   task automatic runToHalt(input int k, input int d);
      int acc;
      int pcErr = 0;
      int stErr = 0;
      int runCycles;
      loadProgram(k + 1, 1'b1, acc);
      checkOutput("run_load_accepted", 32'(acc), 32'(k + 1));
      bus.div = DivW'(d);
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      runCycles = (k + 1) * (d + 1);
      for (int j = 0; j < runCycles; j++) begin
         @(negedge clk);
         if (bus.PC_en !== ((j % (d + 1)) == d)) pcErr++;
         if (bus.busy !== 1'b1 || bus.halted !== 1'b0 || bus.proc_rst_n !== 1'b1) stErr++;
         nextCycle();
      end
      @(negedge clk);
      checkOutput($sformatf("run_k%0d_d%0d_schedule", k, d), 32'(pcErr), 32'd0);
      checkOutput($sformatf("run_k%0d_d%0d_status", k, d), 32'(stErr), 32'd0);
      checkOutput("run_halted", 32'(bus.halted), 32'd1);
      checkOutput("run_halt_busy", 32'(bus.busy), 32'd0);
      checkOutput("run_halt_pc_en", 32'(bus.PC_en), 32'd0);
      checkOutput("run_halt_core_live", 32'(bus.proc_rst_n), 32'd1);
      checkOutput("run_count", 32'(bus.instr_count), 32'(k + 1));
      nextCycle();
   endtask

   task automatic stepTwice(input int baseCount);
      for (int s = 0; s < 2; s++) begin
         pulse(1'b0, 1'b0, 1'b1, 1'b0);
         @(negedge clk);
         checkOutput("step_pc_en_high", 32'(bus.PC_en), 32'd1);
         checkOutput("step_busy", 32'(bus.busy), 32'd1);
         nextCycle();
         @(negedge clk);
         checkOutput("step_pc_en_low", 32'(bus.PC_en), 32'd0);
         checkOutput("step_halted", 32'(bus.halted), 32'd1);
         checkOutput("step_count", 32'(bus.instr_count), 32'(baseCount + s + 1));
         nextCycle();
      end
   endtask

   initial begin
      #10000000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc, n, pcErr, k, d;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      bus.div        = '0;
      bus.prog_valid = 1'b0;
      bus.prog_data  = '0;
      bus.prog_last  = 1'b0;
      for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
      #2 rst_n = 1'b0;

      @(negedge clk);
      checkResetOutputs("reset");
      checkMemory("reset");
      rst_n = 1'b1;
      nextCycle();

      // Fixed five-word load
      progWords[0] = 8'h11; progWords[1] = 8'h22; progWords[2] = 8'h33;
      progWords[3] = 8'h44; progWords[4] = 8'h55;
      loadProgram(5, 1'b1, acc);
      checkOutput("five_accepted", 32'(acc), 32'd5);
      checkMemory("five");

      // Self-jump at word 2 with div=3, then two single steps
      progWords[0] = 8'h00; progWords[1] = 8'h00; progWords[2] = 8'b1000_0010;
      runToHalt(2, 3);
      stepTwice(3);

      // Random self-jump positions and divider settings
      for (int t = 0; t < 3; t++) begin
         k = $urandom_range(1, 7);
         d = $urandom_range(0, 15);
         for (int i = 0; i < k; i++) progWords[i] = 8'($urandom() & 32'h7F);
         progWords[k] = 8'h80 | 8'(k);
         runToHalt(k, d);
      end
      checkMemory("after_runs");

      // Seventeen words, no last flag
      for (int i = 0; i < 17; i++) progWords[i] = 8'($urandom() & 32'h3F);
      loadProgram(17, 1'b0, acc);
      checkOutput("overflow_accepted", 32'(acc), 32'd16);
      checkMemory("overflow");

      // div=0: strobe every cycle, stop beats a coincident tick, restart strobes on entry
      bus.div = '0;
      n = $urandom_range(3, 10);
      pcErr = 0;
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         if (bus.PC_en !== 1'b1) pcErr++;
         nextCycle();
      end
      checkOutput("div0_every_cycle", 32'(pcErr), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("stop_suppresses_tick", 32'(bus.PC_en), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("stop_halted", 32'(bus.halted), 32'd1);
      checkOutput("stop_count", 32'(bus.instr_count), 32'(n));
      nextCycle();
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("resume_first_pc_en", 32'(bus.PC_en), 32'd1);
      nextCycle();
      repeat (300) nextCycle();
      @(negedge clk);
      checkOutput("count_saturates", 32'(bus.instr_count), 32'hFF);
      nextCycle();

      // Abort a load after two words; the coincident third word is dropped
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         bus.prog_valid = 1'b1;
         bus.prog_data  = 8'($urandom() & 32'h3F);
         bus.prog_last  = 1'b0;
         @(negedge clk);
         checkOutput("abort_ready", 32'(bus.prog_ready), 32'd1);
         modelMem[i] = bus.prog_data;
         nextCycle();
      end
      bus.prog_valid = 1'b1;
      bus.prog_data  = 8'h9A;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      nextCycle();
      bus.prog_valid = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_ready_low", 32'(bus.prog_ready), 32'd0);
      checkOutput("abort_core_reset", 32'(bus.proc_rst_n), 32'd0);
      nextCycle();
      checkMemory("abort");

      // Asynchronous reset in the middle of a run
      bus.div = DivW'($urandom_range(0, 15));
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) nextCycle();
      @(negedge clk);
      checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      checkResetOutputs("mid_reset");
      for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
      checkMemory("mid_reset");
      rst_n = 1'b1;
      nextCycle();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
